// File: rtl/control_ejecucion_pipeline_if.sv
// rtl/control_ejecucion_pipeline_if.sv - command, fetch and enable bundle of the pipeline execution controller
interface control_ejecucion_pipeline_if #(
  parameter int CANT_BITS_INSTRUCCION = 32,
  parameter int CANT_ETAPAS           = 5,
  parameter int CANT_BITS_CONTADOR    = 32,
  parameter int CANT_BITS_CMD         = 3
);
  logic                             i_cmd_valid;
  logic [CANT_BITS_CMD-1:0]         i_cmd;
  logic [CANT_BITS_INSTRUCCION-1:0] i_instruction_fetch;
  logic                             i_stall_hazard;
  logic [CANT_ETAPAS-1:0]           o_enable_etapas;
  logic                             o_enable_pc;
  logic                             o_halted;
  logic                             o_busy;
  logic [CANT_BITS_CONTADOR-1:0]    o_contador_ciclos;
  logic [2:0]                       o_estado;

  // Controller side
  modport slave (
    input  i_cmd_valid, i_cmd, i_instruction_fetch, i_stall_hazard,
    output o_enable_etapas, o_enable_pc, o_halted, o_busy, o_contador_ciclos, o_estado
  );

  // Debug unit / pipeline side
  modport master (
    output i_cmd_valid, i_cmd, i_instruction_fetch, i_stall_hazard,
    input  o_enable_etapas, o_enable_pc, o_halted, o_busy, o_contador_ciclos, o_estado
  );
endinterface

// File: rtl/control_ejecucion_pipeline.sv
// rtl/control_ejecucion_pipeline.sv - run/step/stop/halt-drain controller for the 5-stage MIPS pipeline
module control_ejecucion_pipeline #(
  parameter int CANT_BITS_INSTRUCCION = 32,
  parameter int CANT_ETAPAS           = 5,
  parameter int CANT_BITS_CONTADOR    = 32,
  parameter int CANT_BITS_CMD         = 3,
  parameter logic [CANT_BITS_INSTRUCCION-1:0] INSTRUCCION_HALT = {CANT_BITS_INSTRUCCION{1'b1}}
) (
  input  logic i_clock,
  input  logic i_reset,
  control_ejecucion_pipeline_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } estado_t;

  localparam logic [CANT_BITS_CMD-1:0] CMD_RUN   = CANT_BITS_CMD'(1);
  localparam logic [CANT_BITS_CMD-1:0] CMD_STEP  = CANT_BITS_CMD'(2);
  localparam logic [CANT_BITS_CMD-1:0] CMD_STOP  = CANT_BITS_CMD'(3);
  localparam logic [CANT_BITS_CMD-1:0] CMD_CLEAR = CANT_BITS_CMD'(4);

  localparam int DW = $clog2(CANT_ETAPAS);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(CANT_ETAPAS - 1);

  estado_t                       estado;
  logic [DW-1:0]                 drain_cnt;
  logic                          drain_por_halt;
  logic [CANT_BITS_CONTADOR-1:0] contador;

  logic busy;
  logic halt_detectado;
  logic cmd_run, cmd_step, cmd_stop, cmd_clear;

  assign busy = (estado == RUN) || (estado == STEP) || (estado == DRAIN);

  // HALT only counts when it is really being fetched, i.e. IF is not frozen by a stall
  assign halt_detectado = ((estado == RUN) || (estado == STEP)) && !bus.i_stall_hazard &&
                          (bus.i_instruction_fetch == INSTRUCCION_HALT);

  assign cmd_run   = bus.i_cmd_valid && (bus.i_cmd == CMD_RUN);
  assign cmd_step  = bus.i_cmd_valid && (bus.i_cmd == CMD_STEP);
  assign cmd_stop  = bus.i_cmd_valid && (bus.i_cmd == CMD_STOP);
  assign cmd_clear = bus.i_cmd_valid && (bus.i_cmd == CMD_CLEAR);

  // State machine, drain countdown and saturating cycle counter
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      estado         <= IDLE;
      drain_cnt      <= '0;
      drain_por_halt <= 1'b0;
      contador       <= '0;
    end else begin
      if (busy && (contador != '1)) begin
        contador <= contador + CANT_BITS_CONTADOR'(1);
      end
      case (estado)
        IDLE: begin
          if (cmd_run) begin
            estado <= RUN;
          end else if (cmd_step) begin
            estado <= STEP;
          end else if (cmd_clear) begin
            contador <= '0;
          end
        end
        RUN: begin
          // HALT wins over a simultaneous STOP so the program still ends in HALTED
          if (halt_detectado || cmd_stop) begin
            estado         <= DRAIN;
            drain_cnt      <= DRAIN_INIT;
            drain_por_halt <= halt_detectado;
          end
        end
        STEP: begin
          if (halt_detectado) begin
            estado         <= DRAIN;
            drain_cnt      <= DRAIN_INIT;
            drain_por_halt <= 1'b1;
          end else begin
            estado <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_cnt <= DW'(1)) begin
            drain_cnt <= '0;
            estado    <= drain_por_halt ? HALTED : IDLE;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED: begin
          if (cmd_clear) begin
            estado   <= IDLE;
            contador <= '0;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

  // Stage/PC enables from the state, with the load-use stall freezing IF, ID and PC
  always_comb begin
    bus.o_enable_etapas = '0;
    bus.o_enable_pc     = 1'b0;
    case (estado)
      RUN, STEP: begin
        bus.o_enable_etapas = '1;
        bus.o_enable_pc     = !bus.i_stall_hazard;
        if (bus.i_stall_hazard) begin
          bus.o_enable_etapas[1:0] = 2'b00;
        end
      end
      DRAIN: begin
        bus.o_enable_etapas    = '1;
        bus.o_enable_etapas[0] = 1'b0;
      end
      default: begin
        bus.o_enable_etapas = '0;
        bus.o_enable_pc     = 1'b0;
      end
    endcase
  end

  assign bus.o_halted          = (estado == HALTED);
  assign bus.o_busy            = busy;
  assign bus.o_contador_ciclos = contador;
  assign bus.o_estado          = estado;

endmodule

// File: tb/tb_control_ejecucion_pipeline.sv
// tb/tb_control_ejecucion_pipeline.sv - scoreboard bench for the pipeline execution controller
module tb_control_ejecucion_pipeline;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_ejecucion_pipeline_if #(.CANT_BITS_CONTADOR(32)) bus_a ();
  control_ejecucion_pipeline_if #(.CANT_BITS_CONTADOR(4))  bus_b ();

  control_ejecucion_pipeline #(.CANT_BITS_CONTADOR(32)) dut_a (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_a)
  );

  control_ejecucion_pipeline #(.CANT_BITS_CONTADOR(4)) dut_b (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_b)
  );

  typedef struct {
    logic [4:0]  en;
    logic        pc;
    logic        halted;
    logic        busy;
    logic [2:0]  estado;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode code, remaining drain cycles, drain destination, counters
  int     m_st;
  int     m_drain;
  bit     m_to_halt;
  longint m_cnt;
  int     m_cnt4;

  task automatic model_reset();
    m_st = 0; m_drain = 0; m_to_halt = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  function automatic exp_t expect_now(input bit st);
    exp_t e;
    e.estado = 3'(m_st);
    e.busy   = (m_st == 1) || (m_st == 2) || (m_st == 3);
    e.halted = (m_st == 4);
    e.cnt    = m_cnt[31:0];
    e.cnt4   = 4'(m_cnt4);
    if (m_st == 1 || m_st == 2) begin
      e.en = st ? 5'b11100 : 5'b11111;
      e.pc = !st;
    end else if (m_st == 3) begin
      e.en = 5'b11110;
      e.pc = 1'b0;
    end else begin
      e.en = 5'b00000;
      e.pc = 1'b0;
    end
    return e;
  endfunction

  task automatic enter_drain(input bit by_halt);
    m_st = 3; m_drain = 4; m_to_halt = by_halt;
  endtask

  task automatic model_step(input bit v, input int c, input logic [31:0] ins, input bit st);
    bit active;
    bit halt_seen;
    active    = (m_st == 1) || (m_st == 2) || (m_st == 3);
    halt_seen = (m_st == 1 || m_st == 2) && !st && (ins == HALT);
    if (active) begin
      if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    case (m_st)
      0: if (v) begin
           if (c == 1) m_st = 1;
           else if (c == 2) m_st = 2;
           else if (c == 4) begin m_cnt = 0; m_cnt4 = 0; end
         end
      1: if (halt_seen) enter_drain(1);
         else if (v && c == 3) enter_drain(0);
      2: if (halt_seen) enter_drain(1);
         else m_st = 0;
      3: begin
           m_drain--;
           if (m_drain == 0) m_st = m_to_halt ? 4 : 0;
         end
      4: if (v && c == 4) begin m_st = 0; m_cnt = 0; m_cnt4 = 0; end
      default: m_st = 0;
    endcase
  endtask

  task automatic drive(input bit v, input int c, input logic [31:0] ins, input bit st);
    bus_a.i_cmd_valid = v; bus_a.i_cmd = 3'(c); bus_a.i_instruction_fetch = ins; bus_a.i_stall_hazard = st;
    bus_b.i_cmd_valid = v; bus_b.i_cmd = 3'(c); bus_b.i_instruction_fetch = ins; bus_b.i_stall_hazard = st;
  endtask

  function automatic logic [31:0] rnd_instr();
    return $urandom & 32'hFFFF_FFFE;
  endfunction

  // One clock period: drive inputs, record what the outputs must be, advance the model
  task automatic cycle(input bit v, input int c, input logic [31:0] ins, input bit st);
    @(posedge clk);
    #1;
    drive(v, c, ins, st);
    exp_q.push_back(expect_now(st));
    model_step(v, c, ins, st);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, rnd_instr(), 0);
  endtask

  task automatic cmd(input int c);
    cycle(1, c, rnd_instr(), 0);
  endtask

  // Reset asserted between edges so its effect must be visible without a clock edge
  task automatic mid_cycle_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive(0, 0, 32'h0, 0);
    model_reset();
    exp_q.push_back(expect_now(0));
    @(posedge clk);
    #1;
    exp_q.push_back(expect_now(0));
    rst = 1'b0;
    model_step(0, 0, 32'h0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("enable_etapas", 32'(bus_a.o_enable_etapas), 32'(e.en));
        chk("enable_pc",     32'(bus_a.o_enable_pc),     32'(e.pc));
        chk("halted",        32'(bus_a.o_halted),        32'(e.halted));
        chk("busy",          32'(bus_a.o_busy),          32'(e.busy));
        chk("estado",        32'(bus_a.o_estado),        32'(e.estado));
        chk("contador",      bus_a.o_contador_ciclos,    e.cnt);
        chk("estado_w4",     32'(bus_b.o_estado),        32'(e.estado));
        chk("contador_w4",   32'(bus_b.o_contador_ciclos), 32'(e.cnt4));
      end
    end
  end

  initial begin
    bit v, st;
    int c;
    logic [31:0] ins;

    // Power-on reset
    rst = 1'b1;
    drive(0, 0, 32'h0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(expect_now(0));
    rst = 1'b0;
    model_step(0, 0, 32'h0, 0);

    // Run 10 instructions, then HALT, drain, HALTED; RUN/STEP ignored there; CLEAR
    cmd(1);
    idle(10);
    cycle(0, 0, HALT, 0);
    idle(6);
    cmd(1);
    cmd(2);
    idle(2);
    cmd(4);
    idle(2);

    // Three single steps separated by gaps
    for (int k = 0; k < 3; k++) begin
      cmd(2);
      idle(3);
    end
    cmd(4);
    idle(1);

    // Stall pulse with HALT held during the stall
    cmd(1);
    idle(3);
    cycle(0, 0, HALT, 1);
    cycle(0, 0, HALT, 1);
    cycle(0, 0, HALT, 0);
    idle(6);
    cmd(4);
    idle(1);

    // STOP together with HALT, then STOP alone
    cmd(1);
    idle(2);
    cycle(1, 3, HALT, 0);
    idle(6);
    cmd(4);
    cmd(1);
    idle(2);
    cmd(3);
    idle(6);

    // Reset in the second drain cycle
    cmd(1);
    idle(3);
    cycle(0, 0, HALT, 0);
    idle(1);
    mid_cycle_reset();
    idle(2);

    // Long run so the 4-bit counter saturates, then stop
    cmd(1);
    idle(20);
    cmd(3);
    idle(6);
    cmd(4);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) == 0);
      c   = $urandom_range(0, 7);
      ins = ($urandom_range(0, 14) == 0) ? HALT : rnd_instr();
      st  = ($urandom_range(0, 4) == 0);
      cycle(v, c, ins, st);
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
